// File: rtl/lc3b_mem_responder_if.sv
// Memory handshake bundle between the LC-3b control/datapath (initiator)
// and the memory responder. mem_err is carried here so the checker flag
// travels with the bus it monitors.
interface lc3b_mem_responder_if;
  logic [15:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic        mem_err;

  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  mem_rdata, mem_resp, mem_err
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output mem_rdata, mem_resp, mem_err
  );
endinterface

// File: rtl/lc3b_mem_responder.sv
// Cycle-accurate word memory answering the LC-3b mem_read/mem_write
// handshake after LATENCY cycles with a one-cycle mem_resp pulse.
// Optional protocol checker: define LC3B_MEM_PROTO_CHECK_EN to drive a
// sticky mem_err; otherwise mem_err is tied low.
//
//   state | meaning
//   IDLE  | waiting for a request; latches address/data/mask/op on accept
//   BUSY  | counting down latency; request drop aborts without access
//   RESP  | mem_resp high; enabled bytes written at the end of this cycle
module lc3b_mem_responder #(
  parameter int LATENCY   = 3,
  parameter int ADDR_BITS = 12
) (
  input logic                 clk,
  input logic                 reset,
  lc3b_mem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        accept;
  logic        cap_rdata;
  logic        req;

  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [1:0]  be_q;
  logic        wr_q;
  logic [15:0] rdata_q;

  logic [ADDR_BITS-1:0] rd_idx;
  logic [ADDR_BITS-1:0] wr_idx;
  logic [15:0] mem_array [0:(1<<ADDR_BITS)-1];

  // Upper address bits and bit 0 only matter to the checker; they alias otherwise.
  logic unused_addr_q;
  assign unused_addr_q = ^addr_q;

  assign req    = bus.mem_read | bus.mem_write;
  assign wr_idx = addr_q[ADDR_BITS:1];
  // With LATENCY=1 the read happens on the accept edge, before the address is latched.
  assign rd_idx = (state == IDLE) ? bus.mem_address[ADDR_BITS:1] : addr_q[ADDR_BITS:1];

  // State and latency counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state, counter and capture strobes.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    accept    = 1'b0;
    cap_rdata = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_n   = RESP;
            cap_rdata = ~bus.mem_write;
          end else begin
            state_n = BUSY;
            cnt_n   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (!req) begin
          state_n = IDLE;
        end else if (cnt == 4'd0) begin
          state_n   = RESP;
          cap_rdata = ~wr_q;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Request latch; a read+write collision is latched as a write.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      addr_q  <= bus.mem_address;
      wdata_q <= bus.mem_wdata;
      be_q    <= bus.mem_byte_enable;
      wr_q    <= bus.mem_write;
    end
  end

  // Read data register, only touched by completing reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= 16'h0000;
    end else if (cap_rdata) begin
      rdata_q <= mem_array[rd_idx];
    end
  end

  // Byte-masked array write at the end of RESP; contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && state == RESP && wr_q) begin
      if (be_q[0]) mem_array[wr_idx][7:0]  <= wdata_q[7:0];
      if (be_q[1]) mem_array[wr_idx][15:8] <= wdata_q[15:8];
    end
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.mem_resp  = (state == RESP);

`ifdef LC3B_MEM_PROTO_CHECK_EN
  logic err_q;
  logic both_ops;
  logic held_changed;
  logic aborted;

  assign both_ops     = bus.mem_read & bus.mem_write &
                        (state == BUSY || (state == IDLE && req));
  assign held_changed = req && (state == BUSY || state == RESP) &&
                        (bus.mem_address != addr_q || bus.mem_wdata != wdata_q ||
                         bus.mem_byte_enable != be_q);
  assign aborted      = (state == BUSY) && !req;

  // Sticky protocol-violation flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (both_ops || held_changed || aborted) begin
      err_q <= 1'b1;
    end
  end

  assign bus.mem_err = err_q;
`else
  assign bus.mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Directed bench for lc3b_mem_responder: one LATENCY=3 and one LATENCY=1
// instance on a shared clock and reset.
module tb_lc3b_mem_responder;

`ifdef LC3B_MEM_PROTO_CHECK_EN
  localparam logic [15:0] PCHK = 16'd1;
`else
  localparam logic [15:0] PCHK = 16'd0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   fails  = 0;

  lc3b_mem_responder_if b3 ();
  lc3b_mem_responder_if b1 ();

  lc3b_mem_responder #(.LATENCY(3), .ADDR_BITS(12)) dut3 (.clk(clk), .reset(reset), .bus(b3));
  lc3b_mem_responder #(.LATENCY(1), .ADDR_BITS(12)) dut1 (.clk(clk), .reset(reset), .bus(b1));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before timeout");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit rd, input bit wr, input logic [15:0] a,
                       input logic [15:0] d, input logic [1:0] be);
    if (sel) begin
      b1.mem_read = rd; b1.mem_write = wr; b1.mem_address = a;
      b1.mem_wdata = d; b1.mem_byte_enable = be;
    end else begin
      b3.mem_read = rd; b3.mem_write = wr; b3.mem_address = a;
      b3.mem_wdata = d; b3.mem_byte_enable = be;
    end
  endtask

  function automatic logic get_resp(input bit sel);
    return sel ? b1.mem_resp : b3.mem_resp;
  endfunction

  function automatic logic [15:0] get_rdata(input bit sel);
    return sel ? b1.mem_rdata : b3.mem_rdata;
  endfunction

  // One access: request at cycle 0, held until mem_resp; optional drop/address change.
  task automatic access(input string tag, input bit sel, input bit rd, input bit wr,
                        input logic [15:0] a, input logic [15:0] d, input logic [1:0] be,
                        input int lat, input int exp_at, input int drop_at,
                        input int chg_at, input logic [15:0] chg_addr,
                        input bit chk_rd, input logic [15:0] exp_rdata);
    int resp_at  = -1;
    int resp_cnt = 0;
    bit dropped  = 1'b0;
    @(posedge clk); #1;
    drive(sel, rd, wr, a, d, be);
    for (int k = 0; k <= lat + 3; k++) begin
      if ((k == drop_at || resp_at >= 0) && !dropped) begin
        drive(sel, 1'b0, 1'b0, a, d, be);
        dropped = 1'b1;
      end
      if (k == chg_at && !dropped) drive(sel, rd, wr, chg_addr, d, be);
      @(negedge clk);
      if (get_resp(sel)) begin
        resp_cnt++;
        if (resp_at < 0) resp_at = k;
      end
      @(posedge clk); #1;
    end
    chk({tag, "_resp_cycle"}, 16'(resp_at), 16'(exp_at));
    chk({tag, "_resp_count"}, 16'(resp_cnt), (exp_at >= 0) ? 16'd1 : 16'd0);
    if (chk_rd) chk({tag, "_rdata"}, get_rdata(sel), exp_rdata);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp3",  {15'd0, b3.mem_resp}, 16'd0);
    chk("rst_rdata3", b3.mem_rdata, 16'h0000);
    chk("rst_err3",   {15'd0, b3.mem_err}, 16'd0);
    chk("rst_resp1",  {15'd0, b1.mem_resp}, 16'd0);
    chk("rst_rdata1", b1.mem_rdata, 16'h0000);
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic write/read at LATENCY=3.
    access("wr_beef", 1'b0, 1'b0, 1'b1, 16'h0040, 16'hBEEF, 2'b11, 3, 3, -1, -1, 16'h0, 1'b1, 16'h0000);
    access("rd_beef", 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 3, 3, -1, -1, 16'h0, 1'b1, 16'hBEEF);
    chk("err_clean", {15'd0, b3.mem_err}, 16'd0);

    // Byte-enable merge, mask 00, aliasing.
    access("wr_1234", 1'b0, 1'b0, 1'b1, 16'h0080, 16'h1234, 2'b11, 3, 3, -1, -1, 16'h0, 1'b0, 16'h0);
    access("wr_ab00", 1'b0, 1'b0, 1'b1, 16'h0080, 16'hAB00, 2'b10, 3, 3, -1, -1, 16'h0, 1'b0, 16'h0);
    access("wr_00cd", 1'b0, 1'b0, 1'b1, 16'h0080, 16'h00CD, 2'b01, 3, 3, -1, -1, 16'h0, 1'b0, 16'h0);
    access("rd_abcd", 1'b0, 1'b1, 1'b0, 16'h0080, 16'h0000, 2'b00, 3, 3, -1, -1, 16'h0, 1'b1, 16'hABCD);
    access("wr_be00", 1'b0, 1'b0, 1'b1, 16'h0080, 16'hFFFF, 2'b00, 3, 3, -1, -1, 16'h0, 1'b1, 16'hABCD);
    access("rd_be00", 1'b0, 1'b1, 1'b0, 16'h0080, 16'h0000, 2'b11, 3, 3, -1, -1, 16'h0, 1'b1, 16'hABCD);
    access("rd_alias", 1'b0, 1'b1, 1'b0, 16'h2081, 16'h0000, 2'b00, 3, 3, -1, -1, 16'h0, 1'b1, 16'hABCD);

    // LATENCY=1: preload then back-to-back held reads.
    access("l1_wr0", 1'b1, 1'b0, 1'b1, 16'h0000, 16'h1111, 2'b11, 1, 1, -1, -1, 16'h0, 1'b0, 16'h0);
    access("l1_wr2", 1'b1, 1'b0, 1'b1, 16'h0002, 16'h2222, 2'b11, 1, 1, -1, -1, 16'h0, 1'b0, 16'h0);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 2'b00);
    @(negedge clk); chk("b2b_c0_resp", {15'd0, b1.mem_resp}, 16'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("b2b_c1_resp", {15'd0, b1.mem_resp}, 16'd1);
    chk("b2b_c1_rdata", b1.mem_rdata, 16'h1111);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00);
    @(negedge clk); chk("b2b_c2_resp", {15'd0, b1.mem_resp}, 16'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("b2b_c3_resp", {15'd0, b1.mem_resp}, 16'd1);
    chk("b2b_c3_rdata", b1.mem_rdata, 16'h2222);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    @(negedge clk); chk("b2b_c4_resp", {15'd0, b1.mem_resp}, 16'd0);

    // Abort during BUSY leaves the word untouched.
    access("pre_0100", 1'b0, 1'b0, 1'b1, 16'h0100, 16'h0F0F, 2'b11, 3, 3, -1, -1, 16'h0, 1'b0, 16'h0);
    access("abort", 1'b0, 1'b0, 1'b1, 16'h0100, 16'h5555, 2'b11, 3, -1, 1, -1, 16'h0, 1'b0, 16'h0);
    chk("abort_err", {15'd0, b3.mem_err}, PCHK);
    access("rd_0100", 1'b0, 1'b1, 1'b0, 16'h0100, 16'h0000, 2'b00, 3, 3, -1, -1, 16'h0, 1'b1, 16'h0F0F);

    // Read and write together is a write; mem_rdata keeps the last read value.
    access("rdwr", 1'b0, 1'b1, 1'b1, 16'h0400, 16'h4242, 2'b11, 3, 3, -1, -1, 16'h0, 1'b1, 16'h0F0F);
    access("rd_0400", 1'b0, 1'b1, 1'b0, 16'h0400, 16'h0000, 2'b00, 3, 3, -1, -1, 16'h0, 1'b1, 16'h4242);

    // Reset during BUSY of a write.
    access("pre_0200", 1'b0, 1'b0, 1'b1, 16'h0200, 16'h7777, 2'b11, 3, 3, -1, -1, 16'h0, 1'b0, 16'h0);
    access("rd_0200a", 1'b0, 1'b1, 1'b0, 16'h0200, 16'h0000, 2'b00, 3, 3, -1, -1, 16'h0, 1'b1, 16'h7777);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 16'h0200, 16'h9999, 2'b11);
    @(negedge clk); chk("rstb_c0_resp", {15'd0, b3.mem_resp}, 16'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk); chk("rstb_c1_resp", {15'd0, b3.mem_resp}, 16'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    @(negedge clk);
    chk("rstb_c2_resp",  {15'd0, b3.mem_resp}, 16'd0);
    chk("rstb_c2_rdata", b3.mem_rdata, 16'h0000);
    chk("rstb_c2_err",   {15'd0, b3.mem_err}, 16'd0);
    for (int k = 3; k < 7; k++) begin
      @(negedge clk);
      chk("rstb_quiet_resp", {15'd0, b3.mem_resp}, 16'd0);
    end
    access("rd_0200b", 1'b0, 1'b1, 1'b0, 16'h0200, 16'h0000, 2'b00, 3, 3, -1, -1, 16'h0, 1'b1, 16'h7777);

    // Address change during BUSY: latched address wins.
    access("pre_0302", 1'b0, 1'b0, 1'b1, 16'h0302, 16'h1111, 2'b11, 3, 3, -1, -1, 16'h0, 1'b0, 16'h0);
    chk("pre_chg_err", {15'd0, b3.mem_err}, 16'd0);
    access("chg_addr", 1'b0, 1'b0, 1'b1, 16'h0300, 16'hC3C3, 2'b11, 3, 3, -1, 1, 16'h0302, 1'b0, 16'h0);
    chk("chg_err", {15'd0, b3.mem_err}, PCHK);
    access("rd_0300", 1'b0, 1'b1, 1'b0, 16'h0300, 16'h0000, 2'b00, 3, 3, -1, -1, 16'h0, 1'b1, 16'hC3C3);
    access("rd_0302", 1'b0, 1'b1, 1'b0, 16'h0302, 16'h0000, 2'b00, 3, 3, -1, -1, 16'h0, 1'b1, 16'h1111);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
